// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw board inputs and the conditioned SoC-facing outputs.
interface input_conditioner_if #(
    parameter int unsigned SW_WIDTH = 8
);
    logic [SW_WIDTH-1:0] sw_raw;
    logic                key_accum_n;
    logic [SW_WIDTH-1:0] switches_wire_export;
    logic                accumulate_wire_export;
    logic                accumulate_pulse;
    logic [7:0]          press_count;

    // Board/stimulus side: drives raw inputs, observes conditioned outputs.
    modport master (
        output sw_raw,
        output key_accum_n,
        input  switches_wire_export,
        input  accumulate_wire_export,
        input  accumulate_pulse,
        input  press_count
    );

    // Conditioner side.
    modport slave (
        input  sw_raw,
        input  key_accum_n,
        output switches_wire_export,
        output accumulate_wire_export,
        output accumulate_pulse,
        output press_count
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces slide switches and the active-low accumulate button,
// producing clean levels, a one-cycle press strobe and a wrapping press count.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SW_WIDTH        = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input_conditioner_if.slave bus
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // A window commits on the edge where the counter steps onto CNT_MAX,
    // i.e. the DEBOUNCE_CYCLES-th consecutive sighting of the new value.
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    logic [SW_WIDTH-1:0] r_sw_s1;
    logic [SW_WIDTH-1:0] r_sw_s2;
    logic                r_key_s1;
    logic                r_key_s2;

    logic [SW_WIDTH-1:0] r_cand;
    logic [SW_WIDTH-1:0] r_sw_out;
    logic [CNT_W-1:0]    r_sw_cnt;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_key_cnt;
    logic [CNT_W-1:0]    w_key_cnt_nxt;
    logic                r_accum;
    logic                w_accum_nxt;
    logic                r_pulse;
    logic                w_pulse_nxt;
    logic [7:0]          r_count;
    logic [7:0]          w_count_nxt;

    // Two-flop synchronizers; the key idles released (1) under reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
        end else begin
            r_sw_s1  <= bus.sw_raw;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= bus.key_accum_n;
            r_key_s2 <= r_key_s1;
        end
    end

    // Switch filter: any bit change restarts the shared window for the whole vector.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cand   <= '0;
            r_sw_cnt <= '0;
            r_sw_out <= '0;
        end else if (r_sw_s2 != r_cand) begin
            r_cand   <= r_sw_s2;
            r_sw_cnt <= '0;
        end else begin
            if (r_sw_cnt < CNT_MAX) begin
                r_sw_cnt <= r_sw_cnt + CNT_W'(1);
            end
            if (r_sw_cnt >= CNT_PRE) begin
                r_sw_out <= r_cand;
            end
        end
    end

    // Button FSM state and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= S_RELEASED;
            r_key_cnt <= '0;
            r_accum   <= 1'b0;
            r_pulse   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_key_cnt <= w_key_cnt_nxt;
            r_accum   <= w_accum_nxt;
            r_pulse   <= w_pulse_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Button FSM next state; only a committed press strobes and counts.
    always_comb begin
        w_state_nxt   = r_state;
        w_key_cnt_nxt = r_key_cnt;
        w_accum_nxt   = r_accum;
        w_pulse_nxt   = 1'b0;
        w_count_nxt   = r_count;
        case (r_state)
            S_RELEASED: begin
                w_key_cnt_nxt = '0;
                if (!r_key_s2) begin
                    w_state_nxt = S_PRESS_WAIT;
                end
            end
            S_PRESS_WAIT: begin
                if (r_key_s2) begin
                    w_state_nxt   = S_RELEASED;
                    w_key_cnt_nxt = '0;
                end else if (r_key_cnt == CNT_PRE) begin
                    w_state_nxt   = S_PRESSED;
                    w_key_cnt_nxt = '0;
                    w_accum_nxt   = 1'b1;
                    w_pulse_nxt   = 1'b1;
                    w_count_nxt   = r_count + 8'(1);
                end else begin
                    w_key_cnt_nxt = r_key_cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                w_key_cnt_nxt = '0;
                if (r_key_s2) begin
                    w_state_nxt = S_RELEASE_WAIT;
                end
            end
            S_RELEASE_WAIT: begin
                if (!r_key_s2) begin
                    w_state_nxt   = S_PRESSED;
                    w_key_cnt_nxt = '0;
                end else if (r_key_cnt == CNT_PRE) begin
                    w_state_nxt   = S_RELEASED;
                    w_key_cnt_nxt = '0;
                    w_accum_nxt   = 1'b0;
                end else begin
                    w_key_cnt_nxt = r_key_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt   = S_RELEASED;
                w_key_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.switches_wire_export   = r_sw_out;
    assign bus.accumulate_wire_export = r_accum;
    assign bus.accumulate_pulse       = r_pulse;
    assign bus.press_count            = r_count;

endmodule
